// File: rtl/rv_pkg.sv
// Shared encodings for the fetch unit: PC source select, fault codes,
// FSM states and the reset instruction.
package rv_pkg;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_BRANCH = 2'b01,
        PC_ALU    = 2'b10,
        PC_RSVD   = 2'b11
    } pcsrc_e;

    typedef enum logic [1:0] {
        FC_NONE     = 2'b00,
        FC_MISALIGN = 2'b01,
        FC_TIMEOUT  = 2'b10,
        FC_BAD_SRC  = 2'b11
    } fault_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_HOLD  = 2'b10,
        ST_FAULT = 2'b11
    } state_e;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC target mux with reserved-select and word-alignment checks.
// Pure combinational; all sums wrap modulo 2^XLEN.
module next_pc_sel
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [1:0]      pcsrc,
    input  logic [XLEN-1:0] imm_ext,
    input  logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] target,
    output logic            misaligned,
    output logic            bad_src
);

    always_comb begin
        target  = pc;
        bad_src = 1'b0;
        case (pcsrc_e'(pcsrc))
            PC_PLUS4:  target = pc + XLEN'(4);
            PC_BRANCH: target = pc + imm_ext;
            // jalr clears bit 0 of the computed address
            PC_ALU:    target = alu_result & ~XLEN'(1);
            default:   bad_src = 1'b1;
        endcase
    end

    assign misaligned = (target[1:0] != 2'b00);

endmodule

// File: rtl/instr_fetch_unit.sv
// PC holder and single-outstanding instruction fetcher over a req/ack port;
// exposes the captured instruction and its decoded fields until retire.
//
// state | meaning
// IDLE  | one cycle after reset release, no request
// FETCH | imem_req high at pc, waiting for ack (timeout watched)
// HOLD  | instruction captured, fields valid, waiting for retire
// FAULT | sticky error, no requests, left only by rst
module instr_fetch_unit
    import rv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              MAX_WAIT = 15
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [6:0]      opcode,
    output logic [2:0]      func3,
    output logic [6:0]      func7,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic [1:0]      PCSrc,
    input  logic [XLEN-1:0] imm_ext,
    input  logic [XLEN-1:0] alu_result,
    input  logic            retire,
    output logic            fault,
    output logic [1:0]      fault_code
);

    localparam int           CW       = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_LIM = CW'(MAX_WAIT);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     instr_q;
    logic [1:0]      code_q;
    logic [CW-1:0]   wait_q;

    logic [XLEN-1:0] target;
    logic            misaligned;
    logic            bad_src;
    logic            retire_ok;
    logic            timeout;

    next_pc_sel #(.XLEN(XLEN)) u_next_pc_sel (
        .pc         (pc_q),
        .pcsrc      (PCSrc),
        .imm_ext    (imm_ext),
        .alu_result (alu_result),
        .target     (target),
        .misaligned (misaligned),
        .bad_src    (bad_src)
    );

    // An ack in the same cycle the counter reaches the limit still wins.
    assign timeout   = (state_q == ST_FETCH) && !imem_ack && (wait_q == WAIT_LIM);
    assign retire_ok = (state_q == ST_HOLD) && retire && !bad_src && !misaligned;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack)     state_d = ST_HOLD;
                else if (timeout) state_d = ST_FAULT;
            end
            ST_HOLD: begin
                if (retire) state_d = retire_ok ? ST_FETCH : ST_FAULT;
            end
            default:  state_d = ST_FAULT;
        endcase
    end

    always_comb begin
        imem_req    = (state_q == ST_FETCH);
        instr_valid = (state_q == ST_HOLD);
        fault       = (state_q == ST_FAULT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            code_q  <= FC_NONE;
            wait_q  <= '0;
        end else begin
            if (state_q == ST_FETCH && imem_ack)
                instr_q <= imem_rdata;
            if (retire_ok)
                pc_q <= target;
            // Counter is held at zero outside FETCH, so every FETCH entry starts clean.
            if (state_q == ST_FETCH && !imem_ack && wait_q != WAIT_LIM)
                wait_q <= wait_q + CW'(1);
            else if (state_q != ST_FETCH)
                wait_q <= '0;
            if (timeout)
                code_q <= FC_TIMEOUT;
            else if (state_q == ST_HOLD && retire && bad_src)
                code_q <= FC_BAD_SRC;
            else if (state_q == ST_HOLD && retire && misaligned)
                code_q <= FC_MISALIGN;
        end
    end

    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign pc_plus4   = pc_q + XLEN'(4);
    assign instr      = instr_q;
    assign fault_code = code_q;

    assign opcode = instr_q[6:0];
    assign rd     = instr_q[11:7];
    assign func3  = instr_q[14:12];
    assign rs1    = instr_q[19:15];
    assign rs2    = instr_q[24:20];
    assign func7  = instr_q[31:25];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a vector table of fetch/retire
// steps with an expected-fetch-address queue, plus multi-cycle corner cases.
module tb_instr_fetch_unit;

    localparam int MAX_WAIT = 15;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk, rst;
    logic        imem_req, imem_ack, instr_valid, retire, fault;
    logic [31:0] imem_addr, imem_rdata, instr, pc, pc_plus4, imm_ext, alu_result;
    logic [6:0]  opcode, func7;
    logic [2:0]  func3;
    logic [4:0]  rs1, rs2, rd;
    logic [1:0]  PCSrc, fault_code;

    instr_fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr),
        .opcode(opcode), .func3(func3), .func7(func7), .rs1(rs1), .rs2(rs2), .rd(rd),
        .pc(pc), .pc_plus4(pc_plus4),
        .PCSrc(PCSrc), .imm_ext(imm_ext), .alu_result(alu_result), .retire(retire),
        .fault(fault), .fault_code(fault_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst_first;
        int          delay;
        logic [31:0] word;
        logic [1:0]  src;
        logic [31:0] imm;
        logic [31:0] alu;
        logic [1:0]  exp_code;
    } vec_t;

    vec_t        vecs[10];
    logic [31:0] exp_q[$];
    logic [31:0] model_pc;
    int          ntests = 0;
    int          nfail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [1:0] s,
                                               input logic [31:0] imm, input logic [31:0] alu);
        case (s)
            2'b00:   return p + 32'd4;
            2'b01:   return p + imm;
            2'b10:   return {alu[31:1], 1'b0};
            default: return p;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; imem_ack = 1'b0; retire = 1'b0; PCSrc = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp_q.push_back(RESET_PC);
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (imem_req) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
        ntests++;
        nfail++;
        $display("FAIL wait_req: got no imem_req within 40 cycles, expected imem_req=1");
    endtask

    // Waits for a request, checks the address against the queue, acks after
    // 'delay' idle FETCH cycles and checks the HOLD-state outputs.
    task automatic do_fetch(input logic [31:0] word, input int delay, input bit poke_retire);
        bit ok;
        wait_req(ok);
        if (!ok) return;
        if (exp_q.size() == 0) begin
            ntests++; nfail++;
            $display("FAIL fetch_addr: got %h expected no fetch (queue empty)", imem_addr);
            model_pc = imem_addr;
        end else begin
            model_pc = exp_q.pop_front();
            chk("fetch_addr", imem_addr, model_pc);
        end
        for (int i = 0; i < delay; i++) begin
            if (poke_retire && i == 0) begin
                retire = 1'b1; PCSrc = 2'b01; imm_ext = 32'h40;
            end
            @(negedge clk);
            retire = 1'b0; PCSrc = 2'b00;
        end
        imem_ack = 1'b1; imem_rdata = word;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("instr_valid", {31'b0, instr_valid}, 32'd1);
        chk("fault_clear", {31'b0, fault}, 32'd0);
        chk("instr", instr, word);
        chk("opcode", {25'b0, opcode}, {25'b0, word[6:0]});
        chk("rd", {27'b0, rd}, {27'b0, word[11:7]});
        chk("func3", {29'b0, func3}, {29'b0, word[14:12]});
        chk("rs1", {27'b0, rs1}, {27'b0, word[19:15]});
        chk("rs2", {27'b0, rs2}, {27'b0, word[24:20]});
        chk("func7", {25'b0, func7}, {25'b0, word[31:25]});
        chk("pc", pc, model_pc);
        chk("pc_plus4", pc_plus4, model_pc + 32'd4);
    endtask

    task automatic do_retire(input logic [1:0] s, input logic [31:0] imm, input logic [31:0] alu);
        retire = 1'b1; PCSrc = s; imm_ext = imm; alu_result = alu;
        @(negedge clk);
        retire = 1'b0; PCSrc = 2'b00;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, expected finish before 100us");
        $fatal(1, "timeout");
    end

    initial begin
        bit   ok;
        int   cnt;
        logic [31:0] tgt;

        vecs[0] = '{1, 1, 32'h00500093, 2'b00, 32'h0,        32'h0,   2'b00};
        vecs[1] = '{0, 0, 32'h00A00113, 2'b00, 32'h0,        32'h0,   2'b00};
        vecs[2] = '{0, 2, 32'h40208233, 2'b01, 32'hFFFFFFF8, 32'h0,   2'b00};
        vecs[3] = '{0, 0, 32'hFE000EE3, 2'b01, 32'hFFFFFFF0, 32'h0,   2'b00};
        vecs[4] = '{0, 3, 32'h0000006F, 2'b01, 32'h00000014, 32'h0,   2'b00};
        vecs[5] = '{0, 1, 32'h000080E7, 2'b10, 32'h0,        32'h101, 2'b00};
        vecs[6] = '{0, 0, 32'h00000013, 2'b00, 32'h0,        32'h0,   2'b00};
        vecs[7] = '{0, 1, 32'h00008067, 2'b10, 32'h0,        32'h102, 2'b01};
        vecs[8] = '{1, 0, 32'h00100073, 2'b11, 32'h0,        32'h0,   2'b11};
        vecs[9] = '{1, 2, 32'h00C58533, 2'b01, 32'h00000002, 32'h0,   2'b01};

        rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; retire = 1'b0;
        PCSrc = 2'b00; imm_ext = '0; alu_result = '0;
        #12;
        chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_fault", {31'b0, fault}, 32'd0);
        chk("rst_fault_code", {30'b0, fault_code}, 32'd0);
        chk("rst_instr", instr, 32'h00000013);
        chk("rst_pc", pc, RESET_PC);

        for (int v = 0; v < 10; v++) begin
            if (vecs[v].rst_first) do_reset();
            do_fetch(vecs[v].word, vecs[v].delay, 1'b0);
            tgt = model_next(model_pc, vecs[v].src, vecs[v].imm, vecs[v].alu);
            if (vecs[v].exp_code == 2'b00) exp_q.push_back(tgt);
            do_retire(vecs[v].src, vecs[v].imm, vecs[v].alu);
            if (vecs[v].exp_code == 2'b00) begin
                chk("vec_no_fault", {31'b0, fault}, 32'd0);
                chk("vec_refetch_req", {31'b0, imem_req}, 32'd1);
            end else begin
                chk("vec_fault", {31'b0, fault}, 32'd1);
                chk("vec_fault_code", {30'b0, fault_code}, {30'b0, vecs[v].exp_code});
                chk("vec_fault_req", {31'b0, imem_req}, 32'd0);
                chk("vec_fault_valid", {31'b0, instr_valid}, 32'd0);
                chk("vec_fault_pc", pc, model_pc);
                @(negedge clk);
                chk("vec_fault_sticky", {31'b0, fault}, 32'd1);
                chk("vec_fault_pc_frozen", pc, model_pc);
            end
        end

        // no ack at all: request lasts MAX_WAIT+1 cycles, then timeout fault
        do_reset();
        wait_req(ok);
        cnt = 0;
        while (imem_req && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        chk("timeout_req_cycles", cnt, MAX_WAIT + 1);
        chk("timeout_fault", {31'b0, fault}, 32'd1);
        chk("timeout_code", {30'b0, fault_code}, 32'd2);
        chk("timeout_req_low", {31'b0, imem_req}, 32'd0);

        // ack arrives exactly when the wait counter reaches MAX_WAIT
        do_reset();
        do_fetch(32'h00500093, MAX_WAIT, 1'b0);
        exp_q.push_back(32'd4);
        do_retire(2'b00, 32'h0, 32'h0);
        do_fetch(32'h00A00113, 0, 1'b0);

        // retire pulsed during FETCH is ignored
        do_reset();
        do_fetch(32'h00100093, 3, 1'b1);
        exp_q.push_back(32'd4);
        do_retire(2'b00, 32'h0, 32'h0);

        // reset mid-FETCH at pc=4, then a late ack during IDLE
        wait_req(ok);
        chk("midrst_pre_addr", imem_addr, 32'd4);
        rst = 1'b1;
        #1;
        chk("midrst_req_drop", {31'b0, imem_req}, 32'd0);
        chk("midrst_pc", pc, RESET_PC);
        @(negedge clk);
        rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
        #1;
        chk("midrst_idle_req", {31'b0, imem_req}, 32'd0);
        @(negedge clk);
        imem_ack = 1'b0;
        chk("midrst_fetch_req", {31'b0, imem_req}, 32'd1);
        chk("midrst_late_ack_ignored", instr, 32'h00000013);
        chk("midrst_valid", {31'b0, instr_valid}, 32'd0);
        exp_q.delete();
        exp_q.push_back(RESET_PC);
        do_fetch(32'h00200113, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
